lif_spike_layer: RTL
====================

// Module: lif_spike_layer
// PURPOSE
//  Downstream stage of the sparse MVM accelerator. Consumes the 3-element result
//  vector streamed out by the MVM (one 8-bit value per toggle of its strobe).
//  Integrates each value into one of 3 leaky integrate-and-fire neurons and emits
//  a 3-bit spike vector per frame. The CPU feeds that vector back as the next
//  MVM spike train.
// PARAMETERS
//  N_NEUR      3       neurons per frame (= MVM result rows); index width 2
//  VAL_W       8       width of incoming result value
//  V_W         10      membrane potential width, unsigned, saturating
//  THRESH      200     fire when updated potential >= THRESH (V_W bits)
//  LEAK_SHIFT  3       leak per frame = V >> LEAK_SHIFT
//  REFRAC      2       frames a neuron is held silent after firing (2-bit counter)
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  clear        in   1      sync pulse: new run; clears potentials/refrac/idx/overrun
//  res_val      in   VAL_W  result value; valid in the cycle res_toggle changes level
//  res_toggle   in   1      result strobe; every level change = one new value
//  spike_out    out  N_NEUR spike vector of last completed frame, bit n = neuron n
//  spike_valid  out  1      1-cycle pulse: spike_out updated this cycle
//  busy         out  1      high in UPDATE and EMIT
//  overrun      out  1      sticky: value arrived while busy (value dropped)
//  frame_cnt    out  8      completed frames, wraps 255->0
// BEHAVIOUR
//  Reset: all outputs 0. V[n]=0, refrac[n]=0, idx=0, tog_q=0, state=COLLECT.
//  Edge detect: tog_q <= res_toggle every cycle; evt = res_toggle ^ tog_q.
//  COLLECT: on evt: buf[idx] <= res_val, idx++.
//   On evt with idx==N_NEUR-1: idx <= 0, go to UPDATE(n=0) next cycle.
//  UPDATE: one neuron per cycle, n = 0,1,2 (shared adder), 3 cycles total.
//   refrac[n]!=0: V[n] <= 0, refrac[n]--, spike[n] <= 0; buf value ignored.
//   else: t = V - (V>>LEAK_SHIFT) + buf[n], computed at V_W+1 bits;
//    saturate to 2^V_W-1.
//    t >= THRESH: spike[n] <= 1, V[n] <= 0, refrac[n] <= REFRAC.
//    else: spike[n] <= 0, V[n] <= t.
//  EMIT: 1 cycle. spike_out <= spike, spike_valid <= 1, frame_cnt++.
//   Then return to COLLECT.
//  Latency: 3rd evt sampled at edge T; spike_valid high in cycle T+4 only.
//  spike_out holds its value until the next EMIT.
//  evt during UPDATE/EMIT: overrun <= 1, value dropped, idx unchanged.
//  clear (any state): V, refrac, idx, overrun, buf <= 0; tog_q <= res_toggle.
//   Go to COLLECT. spike_out and frame_cnt are kept.
//   An evt in the same cycle as clear is discarded.
//   This also resynchronises the strobe phase, e.g. after the MVM's IDLE sets it.
//  Partial frame (<3 values) waits indefinitely; no timeout.
//  rst_n low mid-frame or mid-UPDATE: immediate return to reset values.
//   No spike_valid is emitted for the aborted frame.
// TESTING
//  1 Fresh frame 50,0,250 -> spike_valid exactly 4 cycles after 3rd toggle;
//    spike_out=3'b100; V0=50, V1=0, V2=0.
//  2 Leak: neuron0 gets 100 each frame -> V0 = 100, 188, then 265 fires;
//    bit0 = 0,0,1; V0=0 after frame 3.
//  3 Refractory: neuron2 fires on 250, then gets 255 for 3 frames
//    -> bit2 = 0,0,1; V2 stays 0 in both silent frames.
//  4 Saturation (THRESH=1023): neuron0 fed 255 every frame
//    -> V0 never wraps; spike on the frame it reaches 1023; V0=0 after.
//  5 Overrun: toggle in 2nd UPDATE cycle -> overrun=1, that frame's spikes unaffected;
//    next 3 toggles form a clean frame; clear -> overrun=0.
//  6 Sync: 2 values, then clear (res_toggle=1) -> no spurious evt;
//    next 10,20,30 -> V=10,20,30, spike_out=0, frame_cnt+1.
//    rst_n low in UPDATE -> outputs 0, no spike_valid.

Source files
------------

// File: rtl/lif_spike_layer.sv
// Leaky integrate-and-fire layer: collects one frame of MVM results off a toggle strobe,
// updates each neuron through a shared saturating adder and emits a spike vector per frame.
module lif_spike_layer #(
    parameter int N_NEUR     = 3,
    parameter int VAL_W      = 8,
    parameter int V_W        = 10,
    parameter int THRESH     = 200,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [VAL_W-1:0]  res_val,
    input  logic              res_toggle,
    output logic [N_NEUR-1:0] spike_out,
    output logic              spike_valid,
    output logic              busy,
    output logic              overrun,
    output logic [7:0]        frame_cnt
);
    localparam int IDX_W = 2;
    localparam int REF_W = 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEUR - 1);
    localparam logic [V_W-1:0]   THRESH_V = V_W'(THRESH);
    localparam logic [V_W-1:0]   V_MAX    = {V_W{1'b1}};
    localparam logic [REF_W-1:0] REFRAC_V = REF_W'(REFRAC);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_UPDATE  = 2'd1,
        ST_EMIT    = 2'd2
    } state_t;

    state_t              state_r;
    logic                tog_q_r;
    logic [IDX_W-1:0]    idx_r;
    logic [IDX_W-1:0]    nidx_r;
    logic [VAL_W-1:0]    buf_r    [N_NEUR];
    logic [V_W-1:0]      v_r      [N_NEUR];
    logic [REF_W-1:0]    refrac_r [N_NEUR];
    logic [N_NEUR-1:0]   spike_r;
    logic [N_NEUR-1:0]   spike_out_r;
    logic                spike_valid_r;
    logic                busy_r;
    logic                overrun_r;
    logic [7:0]          frame_cnt_r;

    logic                evt_s;
    logic [V_W-1:0]      v_cur_s;
    logic [V_W:0]        sum_s;
    logic [V_W-1:0]      sat_s;
    logic                fire_s;

    assign evt_s = res_toggle ^ tog_q_r;

    // Shared leak-and-integrate adder for the neuron selected by nidx_r.
    always_comb begin
        v_cur_s = v_r[nidx_r];
        sum_s   = {1'b0, v_cur_s} - {1'b0, (v_cur_s >> LEAK_SHIFT)}
                + {{(V_W + 1 - VAL_W){1'b0}}, buf_r[nidx_r]};
        if (sum_s[V_W]) begin
            sat_s = V_MAX;
        end else begin
            sat_s = sum_s[V_W-1:0];
        end
        fire_s = (sat_s >= THRESH_V);
    end

    // Frame collection, per-neuron update sequencing and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_COLLECT;
            tog_q_r       <= 1'b0;
            idx_r         <= IDX_W'(0);
            nidx_r        <= IDX_W'(0);
            spike_r       <= {N_NEUR{1'b0}};
            spike_out_r   <= {N_NEUR{1'b0}};
            spike_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            overrun_r     <= 1'b0;
            frame_cnt_r   <= 8'd0;
            for (int i = 0; i < N_NEUR; i++) begin
                buf_r[i]    <= {VAL_W{1'b0}};
                v_r[i]      <= {V_W{1'b0}};
                refrac_r[i] <= {REF_W{1'b0}};
            end
        end else if (clear) begin
            // Resampling the strobe here swallows any edge coincident with clear.
            state_r       <= ST_COLLECT;
            tog_q_r       <= res_toggle;
            idx_r         <= IDX_W'(0);
            nidx_r        <= IDX_W'(0);
            spike_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            overrun_r     <= 1'b0;
            for (int i = 0; i < N_NEUR; i++) begin
                buf_r[i]    <= {VAL_W{1'b0}};
                v_r[i]      <= {V_W{1'b0}};
                refrac_r[i] <= {REF_W{1'b0}};
            end
        end else begin
            tog_q_r       <= res_toggle;
            spike_valid_r <= 1'b0;
            case (state_r)
                ST_COLLECT: begin
                    if (evt_s) begin
                        buf_r[idx_r] <= res_val;
                        if (idx_r == LAST_IDX) begin
                            idx_r   <= IDX_W'(0);
                            nidx_r  <= IDX_W'(0);
                            state_r <= ST_UPDATE;
                            busy_r  <= 1'b1;
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                        end
                    end
                end
                ST_UPDATE: begin
                    if (evt_s) begin
                        overrun_r <= 1'b1;
                    end
                    if (refrac_r[nidx_r] != {REF_W{1'b0}}) begin
                        v_r[nidx_r]      <= {V_W{1'b0}};
                        refrac_r[nidx_r] <= refrac_r[nidx_r] - REF_W'(1);
                        spike_r[nidx_r]  <= 1'b0;
                    end else if (fire_s) begin
                        v_r[nidx_r]      <= {V_W{1'b0}};
                        refrac_r[nidx_r] <= REFRAC_V;
                        spike_r[nidx_r]  <= 1'b1;
                    end else begin
                        v_r[nidx_r]      <= sat_s;
                        spike_r[nidx_r]  <= 1'b0;
                    end
                    if (nidx_r == LAST_IDX) begin
                        nidx_r  <= IDX_W'(0);
                        state_r <= ST_EMIT;
                    end else begin
                        nidx_r <= nidx_r + IDX_W'(1);
                    end
                end
                ST_EMIT: begin
                    if (evt_s) begin
                        overrun_r <= 1'b1;
                    end
                    spike_out_r   <= spike_r;
                    spike_valid_r <= 1'b1;
                    frame_cnt_r   <= frame_cnt_r + 8'd1;
                    busy_r        <= 1'b0;
                    state_r       <= ST_COLLECT;
                end
                default: begin
                    state_r <= ST_COLLECT;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign spike_out   = spike_out_r;
    assign spike_valid = spike_valid_r;
    assign busy        = busy_r;
    assign overrun     = overrun_r;
    assign frame_cnt   = frame_cnt_r;
endmodule
